// File: rtl/fft_twiddle_stage_if.sv
// Stream + twiddle-ROM bundle for the FFT twiddle stage.
// The slave side is the stage; the master side is the upstream source, the ROM and the downstream sink.
interface fft_twiddle_stage_if #(
    parameter int DW    = 16,
    parameter int NPTS  = 32,
    parameter int LANES = 4,
    parameter int AW    = $clog2(NPTS)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*2*DW-1:0] in_data;
    logic                  inverse;
    logic                  tw_en;
    logic [LANES*AW-1:0]   tw_addr;
    logic [LANES*2*DW-1:0] tw_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*2*DW-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, inverse, tw_data, out_ready,
        input  in_ready, tw_en, tw_addr, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, inverse, tw_data, out_ready,
        output in_ready, tw_en, tw_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fft_twiddle_stage.sv
// FFT twiddle multiplier: each lane times its ROM twiddle (conjugated for inverse frames),
// rounded half-up and saturated, through a three-stage pipeline that stalls as a whole.
module fft_twiddle_stage #(
    parameter int DW    = 16,
    parameter int NPTS  = 32,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               reset,
    fft_twiddle_stage_if.slave bus
);
    localparam int AW    = $clog2(NPTS);
    localparam int BEATS = NPTS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = 2*DW + 1;
    localparam int SW    = 2*DW;

    localparam logic signed [DW-1:0] MOST_POS   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MOST_NEG   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW:0]   ROUND_BIAS = (PW+1)'(2**(DW-2));
    localparam logic signed [PW:0]   SAT_MAX    = (PW+1)'(2**(DW-1) - 1);
    localparam logic signed [PW:0]   SAT_MIN    = ~SAT_MAX;

    logic                      advance, accept, lastBeat;
    logic [BW-1:0]             beatCnt_q, beatCnt_d;
    logic                      invFrame_q, invFrame_d;
    logic                      s1Valid_q, s1Last_q, s1Inv_q, s1Inv_d;
    logic [LANES*SW-1:0]       s1Data_q;
    logic                      s2Valid_q, s2Last_q;
    logic [LANES-1:0][PW-1:0]  s2Re_q, s2Re_d, s2Im_q, s2Im_d;
    logic                      outValid_q, outLast_q;
    logic [LANES*SW-1:0]       outData_q, outData_d;
    logic [LANES*AW-1:0]       twAddr;

    // One enable for every stage and the ROM keeps S1 data and tw_data aligned through stalls.
    assign advance      = !outValid_q || bus.out_ready;
    assign accept       = bus.in_valid && advance;
    assign lastBeat     = (beatCnt_q == BW'(BEATS - 1));
    assign bus.in_ready = advance;
    assign bus.tw_en    = advance;
    assign bus.tw_addr  = twAddr;
    assign bus.out_valid = outValid_q;
    assign bus.out_last  = outLast_q;
    assign bus.out_data  = outData_q;

    always_comb begin
        twAddr = '0;
        for (int l = 0; l < LANES; l++) begin
            twAddr[l*AW +: AW] = AW'((int'(beatCnt_q) * LANES + l) % NPTS);
        end
    end

    // Beat 0 samples the inverse request on the fly; later beats reuse the frame's latched value.
    always_comb begin
        beatCnt_d  = beatCnt_q;
        invFrame_d = invFrame_q;
        if (accept) begin
            beatCnt_d = lastBeat ? '0 : beatCnt_q + 1'b1;
            if (beatCnt_q == '0) begin
                invFrame_d = bus.inverse;
            end
        end
    end

    assign s1Inv_d = (beatCnt_q == '0) ? bus.inverse : invFrame_q;

    function automatic logic [DW-1:0] roundSat(input logic signed [PW-1:0] v);
        logic signed [PW:0] r;
        r = (PW+1)'(v) + ROUND_BIAS;
        r = r >>> (DW - 1);
        if (r > SAT_MAX) begin
            return MOST_POS;
        end else if (r < SAT_MIN) begin
            return MOST_NEG;
        end
        return r[DW-1:0];
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DW-1:0] ar, ai, wr, wi, wiAdj;

        assign ar = s1Data_q[l*SW + DW +: DW];
        assign ai = s1Data_q[l*SW +: DW];
        assign wr = bus.tw_data[l*SW + DW +: DW];
        assign wi = bus.tw_data[l*SW +: DW];
        // Negating the most-negative value would wrap, so it is pinned to most-positive.
        assign wiAdj = !s1Inv_q ? wi : ((wi == MOST_NEG) ? MOST_POS : -wi);

        assign s2Re_d[l] = PW'(ar) * PW'(wr) - PW'(ai) * PW'(wiAdj);
        assign s2Im_d[l] = PW'(ar) * PW'(wiAdj) + PW'(ai) * PW'(wr);

        assign outData_d[l*SW +: SW] = {roundSat(s2Re_q[l]), roundSat(s2Im_q[l])};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beatCnt_q  <= '0;
            invFrame_q <= 1'b0;
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= '0;
        end else begin
            beatCnt_q  <= beatCnt_d;
            invFrame_q <= invFrame_d;
            if (advance) begin
                s1Valid_q  <= accept;
                s2Valid_q  <= s1Valid_q;
                outValid_q <= s2Valid_q;
                outLast_q  <= s2Valid_q && s2Last_q;
                outData_q  <= outData_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1Data_q <= bus.in_data;
            s1Inv_q  <= s1Inv_d;
            s1Last_q <= accept && lastBeat;
            s2Re_q   <= s2Re_d;
            s2Im_q   <= s2Im_d;
            s2Last_q <= s1Last_q;
        end
    end
endmodule

// File: tb/tb_fft_twiddle_stage.sv
// Self-checking bench for fft_twiddle_stage: directed corner beats plus randomized streams
// compared against an integer-arithmetic reference model and a beat scoreboard.
module tb_fft_twiddle_stage;
    localparam int DW    = 16;
    localparam int NPTS  = 32;
    localparam int LANES = 4;
    localparam int AW    = 5;
    localparam int BEATS = NPTS / LANES;
    localparam int BUSW  = LANES * 2 * DW;
    localparam logic [LANES*AW-1:0] ADDR0 = {5'd3, 5'd2, 5'd1, 5'd0};

    typedef struct {
        logic [BUSW-1:0] data;
        logic            last;
    } expBeatT;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    fft_twiddle_stage_if #(.DW(DW), .NPTS(NPTS), .LANES(LANES)) bus();
    fft_twiddle_stage #(.DW(DW), .NPTS(NPTS), .LANES(LANES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered twiddle ROM with one-cycle latency that holds its output while disabled.
    logic [2*DW-1:0] romTab [NPTS];
    always @(posedge clk) begin
        if (bus.tw_en === 1'b1) begin
            for (int l = 0; l < LANES; l++) begin
                bus.tw_data[l*2*DW +: 2*DW] <= romTab[bus.tw_addr[l*AW +: AW]];
            end
        end
    end

    expBeatT         sb[$];
    int              mBeat = 0;
    bit              mInv = 1'b0;
    logic [BUSW-1:0] stimB [16];

    function automatic logic [DW-1:0] refRound(input longint v);
        longint r;
        longint lim;
        lim = longint'(1) <<< (DW - 1);
        r = (v + (longint'(1) <<< (DW - 2))) >>> (DW - 1);
        if (r > lim - 1) r = lim - 1;
        else if (r < -lim) r = -lim;
        return r[DW-1:0];
    endfunction

    function automatic logic [BUSW-1:0] refBeat(input logic [BUSW-1:0] d, input int beat, input bit inv);
        logic [BUSW-1:0] res;
        logic [2*DW-1:0] a, w;
        longint          ar, ai, wr, wi, lim;
        res = '0;
        lim = longint'(1) <<< (DW - 1);
        for (int l = 0; l < LANES; l++) begin
            a  = d[l*2*DW +: 2*DW];
            w  = romTab[(beat * LANES + l) % NPTS];
            ar = longint'($signed(a[2*DW-1:DW]));
            ai = longint'($signed(a[DW-1:0]));
            wr = longint'($signed(w[2*DW-1:DW]));
            wi = longint'($signed(w[DW-1:0]));
            if (inv) wi = (wi == -lim) ? lim - 1 : -wi;
            res[l*2*DW +: 2*DW] = {refRound(ar * wr - ai * wi), refRound(ar * wi + ai * wr)};
        end
        return res;
    endfunction

    function automatic logic [BUSW-1:0] randBeat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: let inputs settle, score the handshake outcomes, then advance past the edge.
    task automatic tick();
        expBeatT             e;
        logic [LANES*AW-1:0] expAddr;
        #1;
        if (reset) begin
            sb.delete();
            mBeat = 0;
            mInv  = 1'b0;
        end else begin
            checkOutput("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            checkOutput("tw_en", bus.tw_en, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", bus.out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data", bus.out_data, e.data);
                    checkOutput("out_last", bus.out_last, e.last);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int l = 0; l < LANES; l++) expAddr[l*AW +: AW] = AW'((mBeat * LANES + l) % NPTS);
                checkOutput("tw_addr", bus.tw_addr, expAddr);
                if (mBeat == 0) mInv = bus.inverse;
                e.data = refBeat(bus.in_data, mBeat, mInv);
                e.last = (mBeat == BEATS - 1);
                sb.push_back(e);
                mBeat = (mBeat + 1) % BEATS;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [BUSW-1:0] d, input bit inv);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.inverse  = inv;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            done = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        checkOutput("accept_wait", done, 1'b1);
    endtask

    task automatic sendAndCheck(input logic [BUSW-1:0] d, input bit inv, input logic [BUSW-1:0] exp, input string tag);
        drain(3);
        applyStimulus(d, inv);
        checkOutput({tag, "_lat1"}, bus.out_valid, 1'b0);
        tick();
        checkOutput({tag, "_lat2"}, bus.out_valid, 1'b0);
        tick();
        checkOutput({tag, "_valid"}, bus.out_valid, 1'b1);
        checkOutput({tag, "_data"}, bus.out_data, exp);
    endtask

    initial begin
        int sent;
        int outIdx;
        int cyc;
        bit acc;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.inverse   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NPTS; i++) romTab[i] = 32'h7FFF0000;
        tick();
        tick();
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_last", bus.out_last, 1'b0);
        checkOutput("rst_out_data", bus.out_data, '0);
        checkOutput("rst_in_ready", bus.in_ready, 1'b1);
        checkOutput("rst_tw_en", bus.tw_en, 1'b1);
        checkOutput("rst_tw_addr", bus.tw_addr, ADDR0);
        reset = 1'b0;

        // Frame A: identity, saturation, forward twiddle, then an ignored mid-frame inverse.
        sendAndCheck({LANES{32'h40000000}}, 1'b0, {LANES{32'h40000000}}, "identity");
        for (int i = 0; i < NPTS; i++) romTab[i] = 32'h80000000;
        sendAndCheck({LANES{32'h80000000}}, 1'b0, {LANES{32'h7FFF0000}}, "saturate");
        for (int i = 0; i < NPTS; i++) romTab[i] = 32'h00008000;
        sendAndCheck({LANES{32'h40000000}}, 1'b0, {LANES{32'h0000C000}}, "forward");
        sendAndCheck({LANES{32'h40000000}}, 1'b1, {LANES{32'h0000C000}}, "inv_mid_frame");
        for (int b = 4; b < BEATS; b++) applyStimulus(randBeat(), 1'b1);
        sendAndCheck({LANES{32'h40000000}}, 1'b1, {LANES{32'h00004000}}, "inverse");
        sendAndCheck({LANES{32'h40000000}}, 1'b0, {LANES{32'h00004000}}, "inv_held");
        for (int b = 2; b < BEATS; b++) applyStimulus(randBeat(), 1'b0);
        drain(3);

        // Two back-to-back frames with a five-cycle downstream stall in the middle.
        for (int i = 0; i < NPTS; i++) romTab[i] = $urandom;
        romTab[0] = 32'h80008000;
        romTab[9] = 32'h7FFF8000;
        for (int i = 0; i < 16; i++) stimB[i] = randBeat();
        stimB[3] = {LANES{32'h80008000}};
        sent   = 0;
        outIdx = 0;
        for (cyc = 0; cyc < 200 && (sent < 16 || sb.size() != 0); cyc++) begin
            bus.in_valid  = (sent < 16);
            bus.in_data   = stimB[sent % 16];
            bus.inverse   = 1'($urandom);
            bus.out_ready = !(cyc >= 8 && cyc < 13);
            #1;
            if (!bus.out_ready) begin
                checkOutput("stall_in_ready", bus.in_ready, 1'b0);
                checkOutput("stall_tw_en", bus.tw_en, 1'b0);
            end
            if (bus.out_valid && bus.out_ready) begin
                checkOutput("last_position", bus.out_last, (outIdx == 7 || outIdx == 15));
                outIdx++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) sent++;
        end
        bus.out_ready = 1'b1;
        checkOutput("stall_sent", sent, 16);
        checkOutput("stall_emerged", outIdx, 16);
        checkOutput("stall_drained", sb.size(), 0);

        // Random valid/ready traffic over three frames.
        for (int i = 0; i < NPTS; i++) romTab[i] = $urandom;
        drain(3);
        sent = 0;
        for (cyc = 0; cyc < 600 && (sent < 24 || sb.size() != 0); cyc++) begin
            bus.in_data   = randBeat();
            bus.inverse   = 1'($urandom);
            bus.in_valid  = (sent < 24) && ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) sent++;
        end
        bus.out_ready = 1'b1;
        checkOutput("random_sent", sent, 24);
        checkOutput("random_drained", sb.size(), 0);
        drain(2);

        // Reset in the middle of a frame while a beat is also being offered.
        for (int b = 0; b < 6; b++) applyStimulus(randBeat(), 1'b0);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = randBeat();
        tick();
        checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
        checkOutput("midrst_out_last", bus.out_last, 1'b0);
        checkOutput("midrst_out_data", bus.out_data, '0);
        checkOutput("midrst_tw_addr", bus.tw_addr, ADDR0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        checkOutput("midrst_flushed", bus.out_valid, 1'b0);
        applyStimulus(randBeat(), 1'b0);
        drain(4);
        checkOutput("final_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/fft_twiddle_stage.md
FFT_TWIDDLE_STAGE -- requirements
Module: fft_twiddle_stage

Interface
REQ-001 Parameter DW, default 16: width of one real or imaginary component, signed Q1.(DW-1).
REQ-002 Parameter NPTS, default 32: points per frame; power of 2, NPTS >= LANES.
REQ-003 Parameter LANES, default 4: complex samples per beat; power of 2; NPTS/LANES beats per frame.
REQ-004 Derived AW = log2(NPTS), the twiddle index width.
REQ-005 Clock and reset: reset reset, synchronous, active-high; clock clk.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_ready  output  1  stage can accept a beat.
REQ-008 in_data  input  LANES*2*DW  lane l at [l*2DW +: 2DW]; real in the upper DW bits, imaginary in the lower DW bits.
REQ-009 inverse  input  1  conjugate the twiddles for the current frame.
REQ-010 tw_en  output  1  twiddle ROM read enable.
REQ-011 tw_addr  output  LANES*AW  per-lane twiddle index; lane l at [l*AW +: AW].
REQ-012 tw_data  input  LANES*2*DW  ROM output, registered, 1-cycle read latency; the ROM holds its output while tw_en=0; packing same as in_data.
REQ-013 out_valid  output  1  result beat valid.
REQ-014 out_ready  input  1  downstream accepts the beat.
REQ-015 out_data  output  LANES*2*DW  twiddled samples; packing same as in_data.
REQ-016 out_last  output  1  the beat is the final beat of a frame.

Function
REQ-017 advance = !out_valid || out_ready; in_ready SHALL equal advance; tw_en SHALL equal advance.
REQ-018 A beat is accepted on a clock edge where in_valid && in_ready.
REQ-019 Beat counter b runs 0..NPTS/LANES-1, increments only on accept, and wraps to 0 after the last beat.
REQ-020 tw_addr lane l SHALL equal (b*LANES + l) mod NPTS, driven from the registered counter.
REQ-021 The inverse input SHALL be sampled only on acceptance of beat 0 and held for the whole frame; changes mid-frame are ignored.
REQ-022 Pipeline: S1 captures data, the inverse flag, b==last, and valid on the accept edge; S2 registers the full-precision products; S3 registers the rounded result to the outputs.
REQ-023 With no stall, a beat accepted at edge T SHALL appear on the outputs after edge T+2.
REQ-024 With advance=0, all stages SHALL hold their state; there is no loss, no duplication, and order is preserved.
REQ-025 Conjugation, when the frame is inverse: wi' = -wi; for wi = most-negative, wi' = most-positive.
REQ-026 Complex product per lane: re = ar*wr - ai*wi; im = ar*wi + ai*wr; computed exact at 2*DW+1 bits.
REQ-027 Rounding: add 2^(DW-2), then arithmetic shift right by DW-1 (round half up).
REQ-028 Saturation: clamp the rounded result to [-2^(DW-1), 2^(DW-1)-1].
REQ-029 out_last SHALL be high exactly on the output beat that came from input beat NPTS/LANES-1.
REQ-030 Lanes are independent and identical; LANES=1 SHALL work.

Reset
REQ-031 On reset=1 at a clock edge, the following SHALL be cleared: all stage valids, out_valid=0, out_last=0, out_data=0, b=0, and the inverse flag=0.
REQ-032 The reset value of in_ready is 1 and of tw_en is 1.
REQ-033 Reset mid-frame SHALL discard in-flight beats; the next accepted beat is beat 0.
REQ-034 Reset has priority over the handshake in the same cycle.

Verification
REQ-035 Identity: DW=16, lane in 0x4000+j0, tw 0x7FFF+j0 -> out 0x4000+j0, two cycles after accept.
REQ-036 Saturation: in 0x8000+j0, tw 0x8000+j0 -> re 0x7FFF, im 0x0000.
REQ-037 Inverse: in 0x4000+j0, tw 0x0000+j0x8000.
  - Forward frame -> out 0x0000+j0xC000.
  - Inverse frame -> out 0x0000+j0x4000.
  - Toggling inverse at beat 3 has no effect until the next beat 0.
REQ-038 Backpressure: NPTS=32, LANES=4, 16 beats streamed, out_ready low for 5 cycles mid-stream.
  - in_ready and tw_en are low during the stall.
  - All 16 beats emerge in order with correct values.
REQ-039 Frame wrap: 16 consecutive beats.
  - out_last high on output beats 7 and 15 only.
  - tw_addr for beat 8 is lanes {0,1,2,3}.
  - tw_addr for beat 7 is lanes {28,29,30,31}.
REQ-040 Reset mid-frame: reset after beat 5 -> out_valid=0 the next cycle, and the next accepted beat uses tw_addr {0,1,2,3}.
